// File: rtl/inst_buffer_if.sv
// Fetch-to-decode bundle for the instruction buffer.
// The fetch/decode side uses the master modport and the buffer uses the slave modport.
interface inst_buffer_if #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             flush;

    logic             in_valid;
    logic [1:0]       in_inst_valid;
    logic [31:0]      in_pc0;
    logic [31:0]      in_pc1;
    logic [31:0]      in_inst0;
    logic [31:0]      in_inst1;
    logic [1:0]       in_pred_taken;
    logic [31:0]      in_pred_target0;
    logic [31:0]      in_pred_target1;
    logic             in_ready;

    logic [1:0]       out_valid;
    logic [31:0]      out_pc0;
    logic [31:0]      out_pc1;
    logic [31:0]      out_inst0;
    logic [31:0]      out_inst1;
    logic [1:0]       out_pred_taken;
    logic [31:0]      out_pred_target0;
    logic [31:0]      out_pred_target1;
    logic             out_ready;

    logic [PTR_W:0]   count;

    modport master (
        output flush,
        output in_valid, in_inst_valid, in_pc0, in_pc1, in_inst0, in_inst1,
        output in_pred_taken, in_pred_target0, in_pred_target1,
        input  in_ready,
        input  out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
        input  out_pred_taken, out_pred_target0, out_pred_target1,
        output out_ready,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid, in_inst_valid, in_pc0, in_pc1, in_inst0, in_inst1,
        input  in_pred_taken, in_pred_target0, in_pred_target1,
        output in_ready,
        output out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
        output out_pred_taken, out_pred_target0, out_pred_target1,
        input  out_ready,
        output count
    );
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer: a circular FIFO decoupling fetch from decode.
// Takes up to two instructions per cycle (compacted in program order) and
// presents the two oldest entries to decode. A backend redirect empties it.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    inst_buffer_if.slave  bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
    } entry_t;

    // A full two-instruction group only fits while at least two entries are free.
    localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 2);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_next;

    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] head_p1;

    entry_t           in_slot0;
    entry_t           in_slot1;
    entry_t           wr_data0;
    entry_t           wr_data1;
    logic             wr_en0;
    logic             wr_en1;

    logic             ready_int;
    logic [1:0]       valid_int;
    logic             do_push;
    logic             do_pop;
    logic [1:0]       npush;
    logic [1:0]       npop;
    logic [1:0]       eff_push;
    logic [1:0]       eff_pop;

    // Occupancy-derived handshakes; these look only at the registered count.
    always_comb begin
        ready_int    = (count_q <= READY_LIMIT);
        valid_int    = 2'b00;
        valid_int[0] = (count_q != '0);
        valid_int[1] = (count_q > (PTR_W+1)'(1));
    end

    // Compact the incoming group so the oldest valid slot always lands at tail.
    always_comb begin
        in_slot0 = '{pc:          bus.in_pc0,
                     inst:        bus.in_inst0,
                     pred_taken:  bus.in_pred_taken[0],
                     pred_target: bus.in_pred_target0};
        in_slot1 = '{pc:          bus.in_pc1,
                     inst:        bus.in_inst1,
                     pred_taken:  bus.in_pred_taken[1],
                     pred_target: bus.in_pred_target1};

        npush    = {1'b0, bus.in_inst_valid[0]} + {1'b0, bus.in_inst_valid[1]};
        do_push  = bus.in_valid && ready_int && !bus.flush;
        eff_push = do_push ? npush : 2'd0;

        wr_en0   = do_push && (|bus.in_inst_valid);
        wr_en1   = do_push && (&bus.in_inst_valid);
        wr_data0 = bus.in_inst_valid[0] ? in_slot0 : in_slot1;
        wr_data1 = in_slot1;
    end

    // Decode takes every presented slot when it is ready, so pop width follows out_valid.
    always_comb begin
        npop       = {1'b0, valid_int[0]} + {1'b0, valid_int[1]};
        do_pop     = bus.out_ready && !bus.flush;
        eff_pop    = do_pop ? npop : 2'd0;
        count_next = count_q + (PTR_W+1)'(eff_push) - (PTR_W+1)'(eff_pop);
        tail_p1    = tail + PTR_W'(1);
        head_p1    = head + PTR_W'(1);
    end

    // Pointer and occupancy registers; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(eff_pop);
            tail    <= tail + PTR_W'(eff_push);
            count_q <= count_next;
        end
    end

    // Entry storage; only reset clears it, a flush just abandons the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en0) begin
                mem[tail] <= wr_data0;
            end
            if (wr_en1) begin
                mem[tail_p1] <= wr_data1;
            end
        end
    end

    // Present the two oldest entries straight from storage; new writes show up next cycle.
    always_comb begin
        bus.in_ready         = ready_int;
        bus.out_valid        = valid_int;
        bus.count            = count_q;
        bus.out_pc0          = mem[head].pc;
        bus.out_pc1          = mem[head_p1].pc;
        bus.out_inst0        = mem[head].inst;
        bus.out_inst1        = mem[head_p1].inst;
        bus.out_pred_taken   = {mem[head_p1].pred_taken, mem[head].pred_taken};
        bus.out_pred_target0 = mem[head].pred_target;
        bus.out_pred_target1 = mem[head_p1].pred_target;
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: a queue scoreboard tracks every
// accepted instruction, hand sequences cover the multi-cycle corners and a
// vector table exercises mixed push/pop/flush patterns.
module tb_inst_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    typedef struct {
        logic       iv;
        logic [1:0] ivld;
        logic       ordy;
        logic       fl;
        int         exp_count;
    } vec_t;

    logic clk;
    logic rst;

    inst_buffer_if #(.DEPTH(DEPTH)) bus ();

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] next_pc;
    vec_t        vecs[11];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return pc ^ 32'h5A5A_F00F;
    endfunction

    function automatic logic takenOf(input logic [31:0] pc);
        return pc[2] ^ pc[5];
    endfunction

    function automatic logic [31:0] targetOf(input logic [31:0] pc);
        return pc + 32'h0000_0200;
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Compare the DUT's current state with the scoreboard.
    task automatic checkOutput();
        int          n;
        logic [1:0]  exp_ov;
        logic [31:0] a_pc, a_inst, a_tgt;
        logic        a_tk;
        n      = sb.size();
        exp_ov = {n >= 2, n >= 1};
        check("count", 32'(bus.count), 32'(n));
        check("in_ready", 32'(bus.in_ready), (n <= DEPTH - 2) ? 32'd1 : 32'd0);
        check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        for (int i = 0; i < 2; i++) begin
            if (n > i) begin
                a_pc   = (i == 0) ? bus.out_pc0 : bus.out_pc1;
                a_inst = (i == 0) ? bus.out_inst0 : bus.out_inst1;
                a_tk   = bus.out_pred_taken[i];
                a_tgt  = (i == 0) ? bus.out_pred_target0 : bus.out_pred_target1;
                check($sformatf("slot%0d_pc", i), a_pc, sb[i].pc);
                check($sformatf("slot%0d_inst", i), a_inst, sb[i].inst);
                check($sformatf("slot%0d_taken", i), 32'(a_tk), 32'(sb[i].taken));
                check($sformatf("slot%0d_target", i), a_tgt, sb[i].target);
            end
        end
    endtask

    // Drive one cycle of stimulus, check the current outputs, then advance the model.
    task automatic applyStimulus(input logic iv, input logic [1:0] ivld,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [1:0] tk,
                                 input logic [31:0] t0, input logic [31:0] t1,
                                 input logic ordy, input logic fl);
        int   n;
        int   npop;
        logic acc;
        ent_t e;
        bus.in_valid        = iv;
        bus.in_inst_valid   = ivld;
        bus.in_pc0          = p0;
        bus.in_pc1          = p1;
        bus.in_inst0        = instOf(p0);
        bus.in_inst1        = instOf(p1);
        bus.in_pred_taken   = tk;
        bus.in_pred_target0 = t0;
        bus.in_pred_target1 = t1;
        bus.out_ready       = ordy;
        bus.flush           = fl;
        checkOutput();
        n   = sb.size();
        acc = iv && !fl && (n <= DEPTH - 2);
        if (fl) begin
            sb.delete();
        end else begin
            npop = ordy ? ((n >= 2) ? 2 : n) : 0;
            for (int k = 0; k < npop; k++) void'(sb.pop_front());
            if (acc && ivld[0]) begin
                e = '{pc: p0, inst: instOf(p0), taken: tk[0], target: t0};
                sb.push_back(e);
            end
            if (acc && ivld[1]) begin
                e = '{pc: p1, inst: instOf(p1), taken: tk[1], target: t1};
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle with sequential PCs; a rejected group keeps its PCs for the retry.
    task automatic genCycle(input logic iv, input logic [1:0] ivld,
                            input logic ordy, input logic fl);
        logic [31:0] p0, p1;
        logic        acc;
        p0  = next_pc;
        p1  = (ivld == 2'b10) ? next_pc : next_pc + 32'd4;
        acc = iv && !fl && (sb.size() <= DEPTH - 2);
        applyStimulus(iv, ivld, p0, p1, {takenOf(p1), takenOf(p0)},
                      targetOf(p0), targetOf(p1), ordy, fl);
        if (acc) begin
            next_pc = next_pc + 32'd4 * (32'(ivld[0]) + 32'(ivld[1]));
        end else if (fl && iv) begin
            next_pc = next_pc + 32'h100;
        end
    endtask

    task automatic doReset();
        rst                 = 1'b1;
        bus.flush           = 1'b0;
        bus.in_valid        = 1'b0;
        bus.in_inst_valid   = 2'b00;
        bus.in_pc0          = '0;
        bus.in_pc1          = '0;
        bus.in_inst0        = '0;
        bus.in_inst1        = '0;
        bus.in_pred_taken   = 2'b00;
        bus.in_pred_target0 = '0;
        bus.in_pred_target1 = '0;
        bus.out_ready       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'b11, 1'b0, 1'b0, 2};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 1'b0, 3};
        vecs[2]  = '{1'b1, 2'b10, 1'b1, 1'b0, 2};
        vecs[3]  = '{1'b0, 2'b11, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b0, 0};
        vecs[5]  = '{1'b1, 2'b11, 1'b1, 1'b0, 2};
        vecs[6]  = '{1'b1, 2'b11, 1'b1, 1'b0, 2};
        vecs[7]  = '{1'b1, 2'b01, 1'b1, 1'b0, 1};
        vecs[8]  = '{1'b1, 2'b11, 1'b1, 1'b0, 2};
        vecs[9]  = '{1'b1, 2'b11, 1'b0, 1'b1, 0};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 1'b0, 0};

        doReset();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_out_pc0", bus.out_pc0, 32'd0);
        check("rst_out_inst1", bus.out_inst1, 32'd0);
        check("rst_out_target0", bus.out_pred_target0, 32'd0);

        // Basic push: nothing visible in the push cycle, both slots next cycle.
        next_pc = 32'h8000_0000;
        genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        check("basic_out_valid", 32'(bus.out_valid), 32'h3);
        check("basic_pc0", bus.out_pc0, 32'h8000_0000);
        check("basic_pc1", bus.out_pc1, 32'h8000_0004);
        check("basic_count", 32'(bus.count), 32'd2);
        genCycle(1'b0, 2'b00, 1'b0, 1'b1);

        // Compaction: a lone slot1 lands in slot0 of the output.
        applyStimulus(1'b1, 2'b10, 32'hDEAD_0000, 32'h8000_0014, 2'b10,
                      32'h1111_1111, 32'h8000_0100, 1'b0, 1'b0);
        check("compact_count", 32'(bus.count), 32'd1);
        check("compact_out_valid", 32'(bus.out_valid), 32'h1);
        check("compact_pc0", bus.out_pc0, 32'h8000_0014);
        check("compact_taken0", 32'(bus.out_pred_taken[0]), 32'd1);
        check("compact_target0", bus.out_pred_target0, 32'h8000_0100);
        genCycle(1'b0, 2'b00, 1'b0, 1'b1);

        // Fill to full, hold a rejected group, then drain one pair.
        next_pc = 32'h8000_1000;
        repeat (8) genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        check("held_count", 32'(bus.count), 32'd16);
        genCycle(1'b0, 2'b00, 1'b1, 1'b0);
        check("drain_count", 32'(bus.count), 32'd14);
        check("drain_in_ready", 32'(bus.in_ready), 32'd1);

        // Move head to 14 with three entries, then stream across the wrap.
        repeat (6) genCycle(1'b0, 2'b00, 1'b1, 1'b0);
        genCycle(1'b1, 2'b01, 1'b0, 1'b0);
        check("wrap_setup_count", 32'(bus.count), 32'd3);
        for (int i = 0; i < 4; i++) begin
            genCycle(1'b1, 2'b11, 1'b1, 1'b0);
            check($sformatf("wrap_count_%0d", i), 32'(bus.count), 32'd3);
        end

        // Partial pop of a single remaining entry.
        genCycle(1'b0, 2'b00, 1'b1, 1'b0);
        check("partial_out_valid", 32'(bus.out_valid), 32'h1);
        genCycle(1'b0, 2'b00, 1'b1, 1'b0);
        check("partial_count", 32'(bus.count), 32'd0);
        check("partial_out_valid_after", 32'(bus.out_valid), 32'h0);

        // Flush beats a same-cycle push and pop.
        genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        genCycle(1'b1, 2'b01, 1'b0, 1'b0);
        check("flush_pre_count", 32'(bus.count), 32'd5);
        genCycle(1'b1, 2'b11, 1'b1, 1'b1);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_out_valid", 32'(bus.out_valid), 32'h0);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        genCycle(1'b1, 2'b11, 1'b0, 1'b0);
        genCycle(1'b0, 2'b00, 1'b0, 1'b1);

        // Mixed pattern table.
        for (int i = 0; i < 11; i++) begin
            genCycle(vecs[i].iv, vecs[i].ivld, vecs[i].ordy, vecs[i].fl);
            check($sformatf("tbl_count_%0d", i), 32'(bus.count), 32'(vecs[i].exp_count));
        end
        genCycle(1'b0, 2'b00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Decoupling FIFO between the fetch unit's final output register and decode.
- Accepts up to two fetched instructions per cycle with their branch-prediction info. Slots are compacted in program order.
- Presents the two oldest entries to decode each cycle.
- Flushed by a backend redirect.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- PTR_W, $clog2(DEPTH), width of the head and tail pointers.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  backend redirect; discards all contents
- in_valid  in  1  fetch group present this cycle
- in_inst_valid  in  2  per-slot valid; bit0 is the older slot
- in_pc0, in_pc1  in  32  instruction PCs
- in_inst0, in_inst1  in  32  instruction words
- in_pred_taken  in  2  per-slot predicted-taken
- in_pred_target0, in_pred_target1  in  32  predicted targets
- in_ready  out  1  buffer can accept a full group
- out_valid  out  2  entries presented to decode; bit0 is the oldest
- out_pc0, out_pc1  out  32  PCs at head and head+1
- out_inst0, out_inst1  out  32  instruction words at head and head+1
- out_pred_taken  out  2  predicted-taken at head and head+1
- out_pred_target0, out_pred_target1  out  32  predicted targets at head and head+1
- out_ready  in  1  decode consumes every valid output slot this cycle
- count  out  PTR_W+1  current occupancy

Behaviour:
- Storage is a circular array of DEPTH entries of {pc, inst, pred_taken, pred_target}.
- head and tail are PTR_W bits and wrap modulo DEPTH. count is held in a register.
- Reset:
  - head, tail and count are cleared to 0.
  - All storage is cleared to 0.
  - Resulting outputs: out_valid=00, in_ready=1, all out_* data=0.
- in_ready = (count <= DEPTH-2).
  - Combinational from registered count only.
  - No dependence on out_ready, and no same-cycle pop credit.
- Push occurs when in_valid && in_ready && !flush.
  - npush = popcount(in_inst_valid).
  - in_inst_valid=11: slot0 is written at tail, slot1 at tail+1.
  - in_inst_valid=01 or 10: the single valid slot is written at tail.
  - in_inst_valid=00: nothing is written.
  - tail advances by npush.
- If in_valid && !in_ready, the group is ignored. Fetch must hold it and retry.
- Output slots:
  - out_valid[0] = (count >= 1).
  - out_valid[1] = (count >= 2).
  - Slot0 data comes from entry head; slot1 data from entry (head+1) mod DEPTH.
  - Output data is driven combinationally from storage.
  - Entries written this cycle become visible next cycle; there is no bypass.
- Pop occurs when out_ready && !flush.
  - npop = popcount(out_valid).
  - head advances by npop.
- Simultaneous push and pop: count_next = count + npush - npop, computed at PTR_W+1 bits.
  - Cannot overflow, because a push requires count <= DEPTH-2.
  - Cannot underflow, because npop <= count.
- Flush has the highest priority.
  - head, tail and count return to 0 next cycle.
  - Any same-cycle push or pop has no effect.
  - Storage is not cleared.
  - rst takes precedence over flush.
- Ordering: entries leave strictly in arrival order, including across pointer wrap (index DEPTH-1 to 0).
- Full: count=DEPTH-1 or DEPTH gives in_ready=0. Output continues to drain normally.
- Empty: count=0 gives out_valid=00. out_ready is a don't-care.

Test Plan:
- Reset: assert rst for 2 cycles -> out_valid=00, in_ready=1, count=0, out_pc0=0.
- Basic push:
  - Stimulus: in_valid=1, in_inst_valid=11, pc0=0x80000000, pc1=0x80000004, out_ready=0.
  - Same cycle: out_valid=00.
  - Next cycle: out_valid=11, out_pc0=0x80000000, out_pc1=0x80000004, count=2.
- Compaction:
  - Stimulus: empty buffer, in_inst_valid=10, pc1=0x80000014, in_pred_taken=10, target1=0x80000100.
  - Next cycle: count=1, out_valid=01, out_pc0=0x80000014, out_pred_taken[0]=1, out_pred_target0=0x80000100.
- Fill and backpressure (DEPTH=16):
  - Stimulus: 8 full groups with out_ready=0.
  - Response: count=16 and in_ready=0. A 9th group held on the inputs is not written; count stays 16.
  - Then out_ready=1 for 1 cycle -> count=14, in_ready=1.
- Wrap with simultaneous push and pop:
  - Setup: head=14, count=3. Push 2 and pop 2 for 4 cycles with PCs incrementing by 4.
  - Response: count stays 3 throughout and the output PC sequence is strictly sequential across index 15->0.
- Partial pop: count=1 with out_ready=1 -> out_valid=01, count=0 next cycle, head advances by 1.
- Flush precedence:
  - Stimulus: count=5, with flush=1, a full push and out_ready=1 in the same cycle.
  - Next cycle: count=0, out_valid=00, in_ready=1.
  - The pushed group never appears at the output.
